// File: rtl/priority_queue_kv.sv
// Sorted key/payload priority queue with a zero-latency head read.
// Define PQ_OVERFLOW_EVICT_EN to accept pushes while full and evict the worst entry.
module priority_queue_kv #(
    parameter int DEPTH     = 32,
    parameter int KEY_W     = 16,
    parameter int DATA_W    = 32,
    parameter int MAX_FIRST = 0,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              i_flush,
    input  logic              i_push_valid,
    input  logic [KEY_W-1:0]  i_push_key,
    input  logic [DATA_W-1:0] i_push_data,
    output logic              o_push_ready,
    output logic              o_pop_valid,
    output logic [KEY_W-1:0]  o_pop_key,
    output logic [DATA_W-1:0] o_pop_data,
    input  logic              i_pop_ready,
    output logic [CW-1:0]     o_count,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_evict_valid,
    output logic [KEY_W-1:0]  o_evict_key,
    output logic [DATA_W-1:0] o_evict_data
);

    logic [KEY_W-1:0]  key_q  [DEPTH];
    logic [KEY_W-1:0]  key_d  [DEPTH];
    logic [KEY_W-1:0]  base_k [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [DATA_W-1:0] base_d [DEPTH];
    logic [CW-1:0]     cnt_q, cnt_d, cnt_base, pos;
    logic              pop_fire, push_fire;

    function automatic logic better(input logic [KEY_W-1:0] a,
                                    input logic [KEY_W-1:0] b);
        return (MAX_FIRST != 0) ? (a > b) : (a < b);
    endfunction

    assign o_count     = cnt_q;
    assign o_empty     = (cnt_q == '0);
    assign o_full      = (cnt_q == CW'(DEPTH));
    assign o_pop_valid = !o_empty & !i_flush;
    assign o_pop_key   = key_q[0];
    assign o_pop_data  = data_q[0];
    assign pop_fire    = o_pop_valid & i_pop_ready;
    assign push_fire   = i_push_valid & o_push_ready;

`ifdef PQ_OVERFLOW_EVICT_EN
    assign o_push_ready = !i_flush;
`else
    assign o_push_ready = !i_flush & (!o_full | pop_fire);
`endif

    always_comb begin
        // Remove the head first; the push is then inserted among the rest.
        for (int i = 0; i < DEPTH; i++) begin
            base_k[i] = key_q[i];
            base_d[i] = data_q[i];
        end
        if (pop_fire) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                base_k[i] = key_q[i+1];
                base_d[i] = data_q[i+1];
            end
        end
        cnt_base = cnt_q - CW'(pop_fire);
        // Slot after every stored key that is better or equal: stable order.
        pos = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < cnt_base && !better(i_push_key, base_k[i]))
                pos = CW'(i + 1);
        end
        for (int i = 0; i < DEPTH; i++) begin
            key_d[i]  = base_k[i];
            data_d[i] = base_d[i];
        end
        if (push_fire) begin
            for (int i = 1; i < DEPTH; i++) begin
                if (CW'(i) > pos) begin
                    key_d[i]  = base_k[i-1];
                    data_d[i] = base_d[i-1];
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == pos) begin
                    key_d[i]  = i_push_key;
                    data_d[i] = i_push_data;
                end
            end
        end
        cnt_d = cnt_base;
        if (i_flush)
            cnt_d = '0;
        else if (push_fire && cnt_base != CW'(DEPTH))
            cnt_d = cnt_base + CW'(1);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                key_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            for (int i = 0; i < DEPTH; i++) begin
                key_q[i]  <= key_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

`ifdef PQ_OVERFLOW_EVICT_EN
    logic              ev_valid_q, ev_valid_d;
    logic [KEY_W-1:0]  ev_key_q, ev_key_d;
    logic [DATA_W-1:0] ev_data_q, ev_data_d;

    // Full without pop: either the old tail or the incoming entry drops out.
    always_comb begin
        ev_valid_d = push_fire & (cnt_base == CW'(DEPTH));
        ev_key_d   = '0;
        ev_data_d  = '0;
        if (ev_valid_d) begin
            if (pos == CW'(DEPTH)) begin
                ev_key_d  = i_push_key;
                ev_data_d = i_push_data;
            end else begin
                ev_key_d  = key_q[DEPTH-1];
                ev_data_d = data_q[DEPTH-1];
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            ev_valid_q <= 1'b0;
            ev_key_q   <= '0;
            ev_data_q  <= '0;
        end else begin
            ev_valid_q <= ev_valid_d;
            ev_key_q   <= ev_key_d;
            ev_data_q  <= ev_data_d;
        end
    end

    assign o_evict_valid = ev_valid_q;
    assign o_evict_key   = ev_key_q;
    assign o_evict_data  = ev_data_q;
`else
    assign o_evict_valid = 1'b0;
    assign o_evict_key   = '0;
    assign o_evict_data  = '0;
`endif

endmodule

// File: tb/tb_priority_queue_kv.sv
// Scoreboard bench for priority_queue_kv against a sorted-queue reference model.
// Also covers MAX_FIRST=1 and asynchronous reset on a second instance.
module tb_priority_queue_kv;

    localparam int DEPTH = 4;
`ifdef PQ_OVERFLOW_EVICT_EN
    localparam bit EVICT = 1'b1;
`else
    localparam bit EVICT = 1'b0;
`endif

    typedef struct {
        logic [7:0]  k;
        logic [15:0] d;
    } ent_t;

    typedef struct {
        bit          ready, valid, fire, full, empty, evv;
        int          cnt;
        logic [7:0]  k, evk;
        logic [15:0] d, evd;
    } exp_t;

    logic        CLK, RSTn;
    logic        i_flush, i_push_valid, i_pop_ready;
    logic [7:0]  i_push_key;
    logic [15:0] i_push_data;
    logic        o_push_ready, o_pop_valid, o_full, o_empty;
    logic [7:0]  o_pop_key, o_evict_key;
    logic [15:0] o_pop_data, o_evict_data;
    logic [2:0]  o_count;
    logic        o_evict_valid;

    logic        m_push_valid, m_pop_ready;
    logic [7:0]  m_push_key;
    logic        m_push_ready, m_pop_valid, m_full, m_empty, m_evict_valid;
    logic [7:0]  m_pop_key, m_evict_key;
    logic [15:0] m_pop_data, m_evict_data;
    logic [2:0]  m_count;

    priority_queue_kv #(.DEPTH(DEPTH), .KEY_W(8), .DATA_W(16),
                        .MAX_FIRST(0)) dut (
        .CLK(CLK), .RSTn(RSTn), .i_flush(i_flush),
        .i_push_valid(i_push_valid), .i_push_key(i_push_key),
        .i_push_data(i_push_data), .o_push_ready(o_push_ready),
        .o_pop_valid(o_pop_valid), .o_pop_key(o_pop_key),
        .o_pop_data(o_pop_data), .i_pop_ready(i_pop_ready),
        .o_count(o_count), .o_full(o_full), .o_empty(o_empty),
        .o_evict_valid(o_evict_valid), .o_evict_key(o_evict_key),
        .o_evict_data(o_evict_data));

    priority_queue_kv #(.DEPTH(DEPTH), .KEY_W(8), .DATA_W(16),
                        .MAX_FIRST(1)) dut_max (
        .CLK(CLK), .RSTn(RSTn), .i_flush(1'b0),
        .i_push_valid(m_push_valid), .i_push_key(m_push_key),
        .i_push_data(16'h0), .o_push_ready(m_push_ready),
        .o_pop_valid(m_pop_valid), .o_pop_key(m_pop_key),
        .o_pop_data(m_pop_data), .i_pop_ready(m_pop_ready),
        .o_count(m_count), .o_full(m_full), .o_empty(m_empty),
        .o_evict_valid(m_evict_valid), .o_evict_key(m_evict_key),
        .o_evict_data(m_evict_data));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int         n_tests = 0;
    int         n_fail  = 0;
    ent_t       mq[$];
    exp_t       exp_q[$];
    logic [7:0] pop_log[$];
    bit         ev_v;
    ent_t       ev_e;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    function automatic bit better(input logic [7:0] a, input logic [7:0] b);
        return a < b;
    endfunction

    task automatic model_insert(input ent_t e);
        int j;
        j = mq.size();
        for (int i = mq.size() - 1; i >= 0; i--)
            if (better(e.k, mq[i].k)) j = i;
        mq.insert(j, e);
    endtask

    task automatic step(input bit fl, input bit pv, input logic [7:0] pk,
                        input logic [15:0] pd, input bit pr);
        exp_t e;
        ent_t n;
        @(negedge CLK);
        i_flush = fl; i_push_valid = pv; i_push_key = pk;
        i_push_data = pd; i_pop_ready = pr;
        e.cnt   = mq.size();
        e.full  = (mq.size() == DEPTH);
        e.empty = (mq.size() == 0);
        e.valid = !e.empty && !fl;
        e.fire  = e.valid && pr;
        e.ready = !fl && (EVICT || !e.full || e.fire);
        e.k = e.fire ? mq[0].k : 8'h0;
        e.d = e.fire ? mq[0].d : 16'h0;
        e.evv = ev_v; e.evk = ev_e.k; e.evd = ev_e.d;
        exp_q.push_back(e);
        ev_v = 1'b0;
        n.k = pk; n.d = pd;
        if (fl) begin
            mq.delete();
        end else begin
            if (e.fire) void'(mq.pop_front());
            if (pv && e.ready) begin
                if (mq.size() < DEPTH) begin
                    model_insert(n);
                end else if (better(pk, mq[DEPTH-1].k)) begin
                    ev_v = 1'b1; ev_e = mq[DEPTH-1];
                    void'(mq.pop_back());
                    model_insert(n);
                end else begin
                    ev_v = 1'b1; ev_e = n;
                end
            end
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 8'h0, 16'h0, 1'b0);
    endtask

    task automatic push(input logic [7:0] k, input logic [15:0] d);
        step(1'b0, 1'b1, k, d, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("push_ready", 32'(o_push_ready), 32'(e.ready));
                chk("pop_valid", 32'(o_pop_valid), 32'(e.valid));
                chk("count", 32'(o_count), 32'(e.cnt));
                chk("full", 32'(o_full), 32'(e.full));
                chk("empty", 32'(o_empty), 32'(e.empty));
                chk("evict_valid", 32'(o_evict_valid), 32'(e.evv));
                if (e.evv) begin
                    chk("evict_key", 32'(o_evict_key), 32'(e.evk));
                    chk("evict_data", 32'(o_evict_data), 32'(e.evd));
                end
                if (e.fire) begin
                    chk("pop_key", 32'(o_pop_key), 32'(e.k));
                    chk("pop_data", 32'(o_pop_data), 32'(e.d));
                    pop_log.push_back(o_pop_key);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [7:0]  k;
        logic [15:0] seq;
        RSTn = 1'b0; i_flush = 0; i_push_valid = 0; i_push_key = 0;
        i_push_data = 0; i_pop_ready = 0;
        m_push_valid = 0; m_push_key = 0; m_pop_ready = 0;
        ev_v = 0; ev_e.k = 0; ev_e.d = 0;
        #3;
        chk("rst_count", 32'(o_count), 0);
        chk("rst_empty", 32'(o_empty), 1);
        chk("rst_full", 32'(o_full), 0);
        chk("rst_pop_valid", 32'(o_pop_valid), 0);
        chk("rst_evict_valid", 32'(o_evict_valid), 0);
        chk("rst_pop_key", 32'(o_pop_key), 0);
        chk("rst_pop_data", 32'(o_pop_data), 0);
        #9 RSTn = 1'b1;

        // Largest-first instance: 5, 200, 17 must pop as 200, 17, 5.
        @(negedge CLK); m_push_valid = 1; m_push_key = 8'd5;
        @(negedge CLK); m_push_key = 8'd200;
        @(negedge CLK); m_push_key = 8'd17;
        @(negedge CLK); m_push_valid = 0; m_pop_ready = 1;
        #2 chk("max_pop0", 32'(m_pop_key), 200);
        chk("max_valid0", 32'(m_pop_valid), 1);
        @(negedge CLK); #2 chk("max_pop1", 32'(m_pop_key), 17);
        @(negedge CLK); #2 chk("max_pop2", 32'(m_pop_key), 5);
        @(negedge CLK); m_pop_ready = 0;
        #2 chk("max_empty", 32'(m_empty), 1);

        // Stable order for equal keys; full only at count 4.
        pop_log.delete();
        push(8'd7, 16'hA); push(8'd3, 16'hB);
        push(8'd9, 16'hC); push(8'd3, 16'hD);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h0, 16'h0, 1'b1);
        #3;
        chk("seq_n", 32'(pop_log.size()), 4);
        if (pop_log.size() == 4) begin
            chk("seq0", 32'(pop_log[0]), 3);
            chk("seq1", 32'(pop_log[1]), 3);
            chk("seq2", 32'(pop_log[2]), 7);
            chk("seq3", 32'(pop_log[3]), 9);
        end

        // Full push with simultaneous pop keeps count at DEPTH.
        push(8'd7, 16'hA); push(8'd3, 16'hB);
        push(8'd9, 16'hC); push(8'd3, 16'hD);
        pop_log.delete();
        step(1'b0, 1'b1, 8'd1, 16'hE, 1'b1);
        step(1'b0, 1'b0, 8'h0, 16'h0, 1'b1);
        #3;
        chk("swap_n", 32'(pop_log.size()), 2);
        if (pop_log.size() == 2) begin
            chk("swap_pop", 32'(pop_log[0]), 3);
            chk("swap_head", 32'(pop_log[1]), 1);
        end

`ifdef PQ_OVERFLOW_EVICT_EN
        step(1'b1, 1'b0, 8'h0, 16'h0, 1'b0);
        push(8'd3, 16'h1); push(8'd3, 16'h2);
        push(8'd7, 16'h3); push(8'd9, 16'h4);
        push(8'd5, 16'h5);
        idle();
        #3;
        chk("evict_tail_v", 32'(o_evict_valid), 1);
        chk("evict_tail_k", 32'(o_evict_key), 9);
        push(8'd10, 16'h6);
        idle();
        #3;
        chk("evict_new_k", 32'(o_evict_key), 10);
`endif

        // Flush with a push pending: nothing stored.
        step(1'b1, 1'b0, 8'h0, 16'h0, 1'b0);
        push(8'd8, 16'h1); push(8'd6, 16'h2); push(8'd4, 16'h3);
        step(1'b1, 1'b1, 8'd2, 16'h4, 1'b0);
        idle();

        seq = 16'h100;
        for (int c = 0; c < 600; c++) begin
            k = 8'($urandom_range(0, 11));
            seq++;
            step($urandom_range(0, 40) == 0, $urandom_range(0, 2) != 0,
                 k, seq, $urandom_range(0, 2) == 0);
        end

        // Asynchronous reset with two entries stored.
        step(1'b1, 1'b0, 8'h0, 16'h0, 1'b0);
        push(8'd20, 16'h1); push(8'd30, 16'h2);
        idle();
        #3 RSTn = 1'b0;
        #1;
        chk("arst_count", 32'(o_count), 0);
        chk("arst_pop_valid", 32'(o_pop_valid), 0);
        chk("arst_empty", 32'(o_empty), 1);
        @(negedge CLK); #1 RSTn = 1'b1;
        mq.delete(); ev_v = 0;
        pop_log.delete();
        push(8'd4, 16'h9);
        step(1'b0, 1'b0, 8'h0, 16'h0, 1'b1);
        idle();
        #3;
        chk("arst_head_n", 32'(pop_log.size()), 1);
        if (pop_log.size() == 1)
            chk("arst_head", 32'(pop_log[0]), 4);
        chk("sb_drained", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/priority_queue_kv.md
PRIORITY_QUEUE_KV -- requirements
Module: priority_queue_kv

Interface
REQ-001 SHALL have parameter DEPTH, default 32: number of entries, minimum 2.
REQ-002 SHALL have parameter KEY_W, default 16: priority key width.
REQ-003 SHALL have parameter DATA_W, default 32: payload width carried with each key.
REQ-004 SHALL have parameter MAX_FIRST, default 0: 0 = smallest key at head, 1 = largest key at head.
REQ-005 CLK  input  1  clock, all state on rising edge.
REQ-006 RSTn  input  1  reset, asynchronous, active-low.
REQ-007 i_flush  input  1  synchronous clear of all entries.
REQ-008 i_push_valid  input  1  push request.
REQ-009 i_push_key  input  KEY_W  key of the pushed entry.
REQ-010 i_push_data  input  DATA_W  payload of the pushed entry.
REQ-011 o_push_ready  output  1  push accepted when high together with i_push_valid.
REQ-012 o_pop_valid  output  1  head entry available.
REQ-013 o_pop_key / o_pop_data  output  KEY_W / DATA_W  head entry.
REQ-014 i_pop_ready  input  1  consumer takes the head entry.
REQ-015 o_count  output  $clog2(DEPTH+1)  number of stored entries.
REQ-016 o_full / o_empty  output  1  count == DEPTH / count == 0.
REQ-017 o_evict_valid / o_evict_key / o_evict_data  output  1 / KEY_W / DATA_W  entry dropped on overflow.

Function
REQ-018 Storage SHALL be kept sorted: entry 0 = head (best key per MAX_FIRST), entries at or above count are don't-care.
REQ-019 Equal keys SHALL pop in arrival order (stable insertion after all existing equal keys).
REQ-020 push_fire = i_push_valid & o_push_ready; pop_fire = o_pop_valid & i_pop_ready.
REQ-021 o_pop_valid SHALL be !o_empty & !i_flush; o_pop_key/o_pop_data SHALL be entry 0 driven directly from registers (zero-cycle read latency).
REQ-022 Without overflow eviction, o_push_ready SHALL be !i_flush & (!o_full | pop_fire).
REQ-023 A pushed entry SHALL be visible at head at earliest the cycle after push_fire, never in the same cycle.
REQ-024 Simultaneous push_fire and pop_fire: pre-push head removed, new entry inserted among the rest, count unchanged; allowed when full.
REQ-025 Push into empty queue with i_pop_ready high: only push takes effect (o_pop_valid was 0).
REQ-026 Pop when empty and push when full (no eviction, no pop) SHALL be ignored, state unchanged.
REQ-027 i_flush SHALL override push and pop: count = 0 next cycle, no handshake completes in the flush cycle.
REQ-028 Key comparison SHALL be unsigned, full KEY_W width.
REQ-029 o_evict_valid SHALL be a single-cycle registered pulse; 0 whenever no eviction occurred in the previous cycle.

Reset
REQ-030 RSTn low SHALL immediately set count 0, o_empty 1, o_full 0, o_pop_valid 0, o_evict_valid 0, o_pop_key/o_pop_data/o_evict_key/o_evict_data 0, all entries 0.
REQ-031 Reset mid-operation SHALL discard all contents and any in-flight push/pop; first valid handshake is possible the cycle after RSTn deasserts.

Configuration
REQ-032 Macro PQ_OVERFLOW_EVICT_EN SHALL enable overflow eviction.
REQ-033 With PQ_OVERFLOW_EVICT_EN: o_push_ready = !i_flush; a push while full without pop_fire SHALL keep count = DEPTH, insert the new entry if its key is strictly better than the tail and evict the tail, otherwise evict the incoming entry; evicted key/data reported on o_evict_* the next cycle.
REQ-034 Without PQ_OVERFLOW_EVICT_EN: REQ-022 applies and o_evict_valid/o_evict_key/o_evict_data SHALL be tied 0.

Verification (DEPTH=4, KEY_W=8, MAX_FIRST=0 unless stated)
REQ-035 Push (7,A),(3,B),(9,C),(3,D) then pop continuously -> pops (3,B),(3,D),(7,A),(9,C); count 4,3,2,1,0; o_full 1 only at count 4.
REQ-036 Full {3,3,7,9}, push key 1 with pop_fire same cycle -> pop returns 3, next head 1, count stays 4.
REQ-037 MAX_FIRST=1: push 5, 200, 17 -> pops 200, 17, 5.
REQ-038 Count 3, i_flush=1 with i_push_valid=1 key 2 -> o_push_ready 0, next cycle count 0, o_empty 1, key 2 not stored.
REQ-039 PQ_OVERFLOW_EVICT_EN, full {3,3,7,9}: push 5 -> next cycle o_evict_valid 1 key 9, contents {3,3,5,7}; push 10 -> evict key 10, contents unchanged.
REQ-040 Count 2, RSTn asserted mid-cycle -> o_count 0, o_pop_valid 0 without waiting for CLK; after release, push 4 -> head 4 next cycle.
